// File: rtl/lsu_pkg.sv
// Shared types for the byte-sequential load/store unit: size codes, FSM states,
// latched request payload and the size-to-byte-count helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Request fields held for the duration of an access (address kept separately).
  typedef struct packed {
    logic        write;
    lsu_size_e   size;
    logic        is_unsigned;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic [2:0] size_to_bytes(input lsu_size_e size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of the little-endian bytes assembled by a load.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] ext_data_c
);

  logic ext_bit_c;

  always_comb begin
    ext_bit_c  = 1'b0;
    ext_data_c = '0;
    case (size)
      SIZE_B: begin
        ext_bit_c  = ~is_unsigned & raw[7];
        ext_data_c = {{24{ext_bit_c}}, raw[7:0]};
      end
      SIZE_H: begin
        ext_bit_c  = ~is_unsigned & raw[15];
        ext_data_c = {{16{ext_bit_c}}, raw[15:0]};
      end
      SIZE_W:  ext_data_c = raw;
      default: ext_data_c = '0;
    endcase
  end

endmodule

// File: rtl/byte_mem_access_unit.sv
// Byte-wide RAM load/store sequencer: one byte per cycle, little-endian, single-cycle response.
// Build option LSU_ALIGN_CHECK_EN rejects misaligned halfword/word requests.
module byte_mem_access_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned MEM_BYTES = 80
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [1:0]        Req_Size,
  input  logic              Req_Unsigned,
  input  logic [ADDR_W-1:0] Req_Address,
  input  logic [31:0]       Req_Wdata,
  output logic              Rsp_Valid,
  output logic [31:0]       Rsp_Data,
  output logic              Rsp_Error,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic              Mem_Write,
  output logic [7:0]        Mem_Wdata,
  input  logic [7:0]        Mem_Rdata
);

  localparam int unsigned CHK_W = ADDR_W + 1;

  lsu_state_e        state;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        k_q;
  logic [31:0]       raw_q;

  lsu_size_e         req_size_c;
  logic [2:0]        req_n_c;
  logic [CHK_W-1:0]  req_end_c;
  logic              req_err_c;
  logic [2:0]        n_q_c;
  logic              last_c;
  logic [1:0]        k_inc_c;
  logic [31:0]       raw_nxt_c;
  logic [31:0]       ext_c;

  // Request decode and rejection; end address computed one bit wider so it cannot wrap.
  always_comb begin
    req_size_c = lsu_size_e'(Req_Size);
    req_n_c    = size_to_bytes(req_size_c);
    req_end_c  = CHK_W'(Req_Address) + CHK_W'(req_n_c);
    req_err_c  = (req_size_c == SIZE_RSV) || (req_end_c > CHK_W'(MEM_BYTES));
`ifdef LSU_ALIGN_CHECK_EN
    if ((req_size_c == SIZE_H && Req_Address[0]) ||
        (req_size_c == SIZE_W && Req_Address[1:0] != 2'b00)) begin
      req_err_c = 1'b1;
    end
`endif
  end

  // Byte counter bookkeeping and load assembly including the byte arriving this cycle.
  always_comb begin
    n_q_c     = size_to_bytes(req_q.size);
    last_c    = (3'(k_q) == (n_q_c - 3'd1));
    k_inc_c   = k_q + 2'd1;
    raw_nxt_c = raw_q;
    raw_nxt_c[{k_q, 3'b000} +: 8] = Mem_Rdata;
  end

  lsu_load_extend u_extend (
    .raw         (raw_nxt_c),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .ext_data_c  (ext_c)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      req_q       <= '0;
      base_q      <= '0;
      k_q         <= '0;
      raw_q       <= '0;
      Req_Ready   <= 1'b1;
      Rsp_Valid   <= 1'b0;
      Rsp_Data    <= '0;
      Rsp_Error   <= 1'b0;
      Mem_Address <= '0;
      Mem_Write   <= 1'b0;
      Mem_Wdata   <= '0;
    end else begin
      Rsp_Valid <= 1'b0;
      Rsp_Data  <= '0;
      Rsp_Error <= 1'b0;
      Mem_Write <= 1'b0;
      case (state)
        IDLE: begin
          if (Req_Valid) begin
            req_q.write       <= Req_Write;
            req_q.size        <= req_size_c;
            req_q.is_unsigned <= Req_Unsigned;
            req_q.wdata       <= Req_Wdata;
            base_q            <= Req_Address;
            k_q               <= '0;
            raw_q             <= '0;
            Req_Ready         <= 1'b0;
            if (req_err_c) begin
              state     <= RESP;
              Rsp_Valid <= 1'b1;
              Rsp_Error <= 1'b1;
            end else begin
              state       <= ACCESS;
              Mem_Address <= Req_Address;
              Mem_Write   <= Req_Write;
              Mem_Wdata   <= Req_Wdata[7:0];
            end
          end
        end
        ACCESS: begin
          raw_q <= raw_nxt_c;
          if (last_c) begin
            state     <= RESP;
            Rsp_Valid <= 1'b1;
            Rsp_Data  <= req_q.write ? 32'd0 : ext_c;
          end else begin
            k_q         <= k_inc_c;
            Mem_Address <= base_q + ADDR_W'(k_inc_c);
            Mem_Write   <= req_q.write;
            Mem_Wdata   <= req_q.wdata[{k_inc_c, 3'b000} +: 8];
          end
        end
        RESP: begin
          state     <= IDLE;
          Req_Ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          Req_Ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/byte_mem_access_unit.md
Name: byte_mem_access_unit

Overview:
- Initiator-side load/store unit for the byte-wide data RAM.
- Accepts one word, halfword or byte request from the CPU datapath over a valid/ready handshake.
- Sequences the access as one byte per cycle on the RAM port, little-endian.
- For loads, returns the assembled and sign/zero-extended result on a single-cycle response strobe.

Parameters:
- ADDR_W, 7, byte-address width of the RAM port.
- MEM_BYTES, 80, number of implemented RAM bytes; the highest legal byte address is MEM_BYTES-1.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- Req_Valid  input  1  request present.
- Req_Ready  output  1  unit can accept a request.
- Req_Write  input  1  1 = store, 0 = load.
- Req_Size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- Req_Unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- Req_Address  input  ADDR_W  base byte address.
- Req_Wdata  input  32  store data; byte k is bits [8k+7:8k].
- Rsp_Valid  output  1  one-cycle completion strobe, for loads and stores.
- Rsp_Data  output  32  load result; 0 for stores and errors.
- Rsp_Error  output  1  request rejected; valid only with Rsp_Valid.
- Mem_Address  output  ADDR_W  RAM byte address.
- Mem_Write  output  1  RAM byte write enable.
- Mem_Wdata  output  8  RAM write byte.
- Mem_Rdata  input  8  RAM read byte, combinational from Mem_Address.

Behaviour:
- Clock and reset:
  - Single clock CLK.
  - Reset RST_N is asynchronous, active-low.
- Reset values, applied immediately on RST_N low, including mid-access:
  - state = IDLE, Req_Ready = 1.
  - Rsp_Valid = 0, Rsp_Data = 0, Rsp_Error = 0.
  - Mem_Address = 0, Mem_Write = 0, Mem_Wdata = 0.
  - Partially written store bytes stay in RAM; no rollback.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Req_Ready = 1.
  - On a rising edge with Req_Valid = 1, the unit latches address, size, write, unsigned and wdata, and clears the byte counter k to 0.
  - Byte count N = 1, 2 or 4 from Req_Size.
  - Error check: Req_Size = 11, or Req_Address + N > MEM_BYTES (computed in ADDR_W+1 bits, no wrap).
  - On error: go to RESP with Rsp_Error = 1, no RAM cycle issued.
  - Otherwise: go to ACCESS.
- ACCESS:
  - Req_Ready = 0.
  - Mem_Address = base + k.
  - Mem_Write = latched write.
  - Mem_Wdata = latched wdata byte k.
  - Loads: Mem_Rdata is captured into result byte k at the rising edge.
  - k increments each cycle; after byte N-1 the state goes to RESP.
- RESP:
  - Rsp_Valid = 1 for exactly one cycle; Req_Ready = 0.
  - Next state is IDLE.
  - Rsp_Data for loads:
    - byte: {24{ext}, b0}.
    - halfword: {16{ext}, b1, b0}.
    - word: {b3, b2, b1, b0}.
    - ext = 0 if unsigned, else the MSB of the top loaded byte.
  - Rsp_Data is 0 for stores and errors.
- Outside ACCESS, Mem_Write = 0 and Mem_Address holds its last value.
- Latency from the accept edge to the Rsp_Valid cycle: N+1 cycles (1 cycle for errors). Throughput is one request per N+2 cycles.
- There is no response backpressure; the consumer must sample Rsp_Valid.
- Req_Valid is ignored outside IDLE; changes to request inputs after accept have no effect.
- Req_Unsigned is ignored for stores.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: halfword at an odd address, or word at an address not a multiple of 4, is an error (RESP with Rsp_Error = 1, no RAM access).
- Undefined: misaligned accesses are legal and handled byte-sequentially; only the range and size checks apply.

Decomposition:
- Package lsu_pkg:
  - Size encodings SIZE_B/SIZE_H/SIZE_W/SIZE_RSV.
  - State enum.
  - Function size_to_bytes.
- One combinational sub-module, lsu_load_extend: inputs raw 32-bit assembled bytes, size and unsigned; output the extended result.

Test Plan:
- Word store then load:
  - Store, address 8, size 10, wdata 0xDEADBEEF: writes to 8, 9, 10, 11 with bytes EF, BE, AD, DE on 4 consecutive cycles; Rsp_Valid 5 cycles after accept, Rsp_Data 0.
  - Load word at 8: Rsp_Data 0xDEADBEEF.
- Byte and halfword load extension, after storing 0x80 at address 3 and 0x8001 at address 4:
  - lb @3 returns 0xFFFFFF80.
  - lbu @3 returns 0x00000080.
  - lh @4 returns 0xFFFF8001.
  - lhu @4 returns 0x00008001.
- Range error:
  - Word at 77: Rsp_Error = 1 one cycle after accept, Mem_Write never asserted.
  - Word at 76 succeeds.
  - Size 11 also errors.
- Handshake:
  - Req_Valid held high continuously: Req_Ready low from accept through RESP.
  - Second request accepted only on return to IDLE; word-to-word spacing is 6 cycles.
- Reset mid-store:
  - RST_N low during the 2nd byte of a word store: Mem_Write drops immediately, Req_Ready = 1, Rsp_Valid = 0.
  - After release, only bytes 0 and 1 are modified in RAM.
- Alignment, run with and without LSU_ALIGN_CHECK_EN:
  - Halfword load at address 5 errors with the macro defined.
  - Without the macro it returns {b6, b5} extended.
